find_keypoints_unit: RTL and testbench
======================================

Name: find_keypoints_unit

Overview:
- Scale-space extremum detector for the SIFT pipeline.
- Scans three octaves in order: O1 at DIMENSION², O2 at (DIMENSION/2)², O3 at (DIMENSION/4)². Each octave has three signed layers L1, L2, L3, held in external read-only BRAMs.
- Each interior pixel of L2 is compared against its 26 neighbours: 8 in L2, 9 in L1, 9 in L3.
- Every strict extremum is written as a packed coordinate word to a keypoint BRAM.

Parameters:
- BIT_DEPTH, 8, signed pixel width of all layer data.
- DIMENSION, 64, octave-1 width and height; power of two, ≥16.

Ports:
- clk  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a full 3-octave scan.
- O1L1_read_addr, O1L2_read_addr, O1L3_read_addr  out  $clog2(DIMENSION²)  octave-1 layer addresses.
- O1L1_data, O1L2_data, O1L3_data  in  BIT_DEPTH signed  octave-1 BRAM outputs.
- O2Lk_read_addr (k=1..3)  out  $clog2((DIMENSION/2)²)  octave-2 addresses; O2Lk_data  in  BIT_DEPTH.
- O3Lk_read_addr (k=1..3)  out  $clog2((DIMENSION/4)²)  octave-3 addresses; O3Lk_data  in  BIT_DEPTH.
- key_write_addr  out  $clog2(DIMENSION²)  keypoint BRAM write address.
- key_wea  out  1  keypoint write strobe.
- keypoint_out  out  2*$clog2(DIMENSION)+1  packed keypoint word: {row, col, is_max}.
- keypoints_done  out  1  level; scan complete.
- in_ocatve_3_latched  out  1  level; high once the octave-3 scan has begun.
- O1_DOG_L2L3_done  out  1  one-cycle pulse when the octave-1 scan finishes.

Behaviour:
- Reset (rst_in=0, async): all outputs and addresses 0; FSM IDLE; keypoint counter 0.
- BRAM model: 2-cycle read latency (HIGH_PERFORMANCE). Data for an address presented at cycle t is valid at t+2. All three layers of an octave are addressed with the same address in parallel.
- Address mapping: addr = row*W + col, where W is the octave width.
- FSM states: IDLE → SCAN_O1 → SCAN_O2 → SCAN_O3 → DONE.
- IDLE → SCAN_O1 on start=1. This clears key_write_addr, keypoints_done and in_ocatve_3_latched.
- start is ignored while scanning.
- DONE holds keypoints_done=1 until the next start.
- Per octave, candidates are row 1..W-2 and col 1..W-2, row-major. Border pixels are never keypoints.
- Per candidate:
  - Issue the 9 window addresses (row-1..row+1 × col-1..col+1), one per cycle.
  - Capture the returned 27 values two cycles after each address.
  - Evaluate the extremum the cycle after the last capture.
  - Pipelining across candidates is permitted; required throughput is ≥1 candidate per 12 cycles.
- Extremum test uses the signed L2 centre value c:
  - Maximum: c strictly greater than all 26 neighbours.
  - Minimum: c strictly less than all 26 neighbours.
  - Any tie means the pixel is not a keypoint.
  - An all-equal neighbourhood is never a keypoint.
- On an extremum, for exactly one cycle:
  - key_wea=1.
  - keypoint_out = {row, col, is_max}. row and col are in the octave's native resolution, zero-extended to $clog2(DIMENSION) bits each. is_max=1 for a maximum, 0 for a minimum.
  - key_write_addr holds the current count.
  - The count increments after the write.
- Counter overflow: when the count reaches DIMENSION²-1, that write occurs. All further extrema are dropped, with key_wea held 0.
- Octave transitions:
  - End of O1: O1_DOG_L2L3_done pulses for one cycle, then SCAN_O2.
  - Entering SCAN_O3: in_ocatve_3_latched is set and held.
  - End of O3: DONE.
- Unused octave address buses hold 0.
- Reset mid-scan aborts immediately to IDLE with all outputs 0.

Decomposition:
- Shared package: BIT_DEPTH default, octave count (3), a state enum (IDLE, SCAN_O1, SCAN_O2, SCAN_O3, DONE), and the keypoint word field layout.
- One sub-module, extremum_window_27: accumulates the 27 signed samples and outputs is_max / is_min.
- The layer BRAMs (xilinx_single_port_ram_read_first) are external instances, not part of this block.

Test Plan:
- All layers constant 0 → start pulse → no key_wea; keypoints_done rises; in_ocatve_3_latched=1; O1_DOG_L2L3_done pulses exactly once.
- O1L2(10,20)=100, all else 0 → exactly one write: keypoint_out={6'd10,6'd20,1'b1}, key_write_addr=0.
- O2L2(5,7)=-127, all else 0 → one write {6'd5,6'd7,1'b0}. The write occurs after O1_DOG_L2L3_done and while in_ocatve_3_latched=0.
- O1L2(10,20)=100 with O1L3(11,21)=100 (tie) → no write. O1L2(0,5)=100 on the border → no write.
- Three separated peaks, one per octave → writes at addresses 0, 1, 2 in octave order. The O3 write occurs with in_ocatve_3_latched=1.
- Assert rst_in=0 mid-O2 → outputs all 0 immediately. A new start rescans from O1 with key_write_addr starting at 0. A start pulse mid-scan has no effect.

Source files
------------

// File: rtl/find_keypoints_unit_pkg.sv
// Shared types and constants for the scale-space keypoint detector.
package find_keypoints_unit_pkg;

    localparam int BIT_DEPTH_DEF = 8;
    localparam int DIMENSION_DEF = 64;
    localparam int NUM_OCTAVES   = 3;
    localparam int OCT_W         = $clog2(NUM_OCTAVES);

    // A 3x3 window is walked as taps 0..8, row-major; tap 4 is the centre.
    localparam int          WINDOW_TAPS   = 9;
    localparam int          WINDOW_CENTRE = 4;
    localparam logic [3:0]  LAST_TAP      = 4'd8;

    // Keypoint word layout, LSB first: is_max, then col, then row.
    localparam int KP_IS_MAX_LSB = 0;
    localparam int KP_COL_LSB    = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN_O1 = 3'd1,
        SCAN_O2 = 3'd2,
        SCAN_O3 = 3'd3,
        DONE    = 3'd4
    } fk_state_e;

    // Row offset (0..2, later biased by -1) of a window tap.
    function automatic logic [1:0] tap_row(input logic [3:0] tap);
        case (tap)
            4'd0, 4'd1, 4'd2: tap_row = 2'd0;
            4'd3, 4'd4, 4'd5: tap_row = 2'd1;
            4'd6, 4'd7, 4'd8: tap_row = 2'd2;
            default:          tap_row = 2'd0;
        endcase
    endfunction

    // Column offset (0..2, later biased by -1) of a window tap.
    function automatic logic [1:0] tap_col(input logic [3:0] tap);
        case (tap)
            4'd0, 4'd3, 4'd6: tap_col = 2'd0;
            4'd1, 4'd4, 4'd7: tap_col = 2'd1;
            4'd2, 4'd5, 4'd8: tap_col = 2'd2;
            default:          tap_col = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/find_keypoints_unit_if.sv
// Keypoint BRAM write bus: the detector drives it, the keypoint memory sinks it.
interface find_keypoints_unit_if #(
    parameter int DIMENSION = 64
);
    localparam int AW = $clog2(DIMENSION * DIMENSION);
    localparam int CW = $clog2(DIMENSION);

    logic [AW-1:0] key_write_addr;
    logic          key_wea;
    logic [2*CW:0] keypoint_out;

    modport master (output key_write_addr, key_wea, keypoint_out);
    modport slave  (input  key_write_addr, key_wea, keypoint_out);
endinterface

// File: rtl/find_keypoints_unit_extremum_window_27.sv
// Holds one 3x3x3 neighbourhood and reports whether its L2 centre is a strict extremum.
module extremum_window_27
    import find_keypoints_unit_pkg::*;
#(
    parameter int BIT_DEPTH = BIT_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cap_en,
    input  logic [3:0]                  cap_tap,
    input  logic signed [BIT_DEPTH-1:0] l1,
    input  logic signed [BIT_DEPTH-1:0] l2,
    input  logic signed [BIT_DEPTH-1:0] l3,
    output logic                        is_max,
    output logic                        is_min
);

    logic signed [BIT_DEPTH-1:0] l1_r [WINDOW_TAPS];
    logic signed [BIT_DEPTH-1:0] l2_r [WINDOW_TAPS];
    logic signed [BIT_DEPTH-1:0] l3_r [WINDOW_TAPS];
    logic signed [BIT_DEPTH-1:0] centre_s;
    logic                        gt_all_s;
    logic                        lt_all_s;

    // Store the three layer samples belonging to one window tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WINDOW_TAPS; i++) begin
                l1_r[i] <= '0;
                l2_r[i] <= '0;
                l3_r[i] <= '0;
            end
        end else if (cap_en && (cap_tap <= LAST_TAP)) begin
            l1_r[cap_tap] <= l1;
            l2_r[cap_tap] <= l2;
            l3_r[cap_tap] <= l3;
        end
    end

    // Centre must strictly beat every one of its 26 neighbours; any tie kills it.
    always_comb begin
        centre_s = l2_r[WINDOW_CENTRE];
        gt_all_s = 1'b1;
        lt_all_s = 1'b1;
        for (int i = 0; i < WINDOW_TAPS; i++) begin
            gt_all_s = gt_all_s & (centre_s > l1_r[i]) & (centre_s > l3_r[i]);
            lt_all_s = lt_all_s & (centre_s < l1_r[i]) & (centre_s < l3_r[i]);
            if (i != WINDOW_CENTRE) begin
                gt_all_s = gt_all_s & (centre_s > l2_r[i]);
                lt_all_s = lt_all_s & (centre_s < l2_r[i]);
            end else begin
                gt_all_s = gt_all_s;
                lt_all_s = lt_all_s;
            end
        end
    end

    assign is_max = gt_all_s;
    assign is_min = lt_all_s;

endmodule

// File: rtl/find_keypoints_unit.sv
// Three-octave scale-space extremum scanner writing packed keypoints to a BRAM.
// Window addresses stream one per cycle; a tag pipeline matched to the 2-cycle
// BRAM latency tells the capture stage which octave/tap/candidate each sample is.
module find_keypoints_unit
    import find_keypoints_unit_pkg::*;
#(
    parameter  int BIT_DEPTH = BIT_DEPTH_DEF,
    parameter  int DIMENSION = DIMENSION_DEF,
    localparam int A1W = $clog2(DIMENSION * DIMENSION),
    localparam int A2W = $clog2((DIMENSION / 2) * (DIMENSION / 2)),
    localparam int A3W = $clog2((DIMENSION / 4) * (DIMENSION / 4)),
    localparam int CW  = $clog2(DIMENSION)
) (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic                        start,
    output logic [A1W-1:0]              O1L1_read_addr,
    output logic [A1W-1:0]              O1L2_read_addr,
    output logic [A1W-1:0]              O1L3_read_addr,
    input  logic signed [BIT_DEPTH-1:0] O1L1_data,
    input  logic signed [BIT_DEPTH-1:0] O1L2_data,
    input  logic signed [BIT_DEPTH-1:0] O1L3_data,
    output logic [A2W-1:0]              O2L1_read_addr,
    output logic [A2W-1:0]              O2L2_read_addr,
    output logic [A2W-1:0]              O2L3_read_addr,
    input  logic signed [BIT_DEPTH-1:0] O2L1_data,
    input  logic signed [BIT_DEPTH-1:0] O2L2_data,
    input  logic signed [BIT_DEPTH-1:0] O2L3_data,
    output logic [A3W-1:0]              O3L1_read_addr,
    output logic [A3W-1:0]              O3L2_read_addr,
    output logic [A3W-1:0]              O3L3_read_addr,
    input  logic signed [BIT_DEPTH-1:0] O3L1_data,
    input  logic signed [BIT_DEPTH-1:0] O3L2_data,
    input  logic signed [BIT_DEPTH-1:0] O3L3_data,
    find_keypoints_unit_if.master       kp,
    output logic                        keypoints_done,
    output logic                        in_ocatve_3_latched,
    output logic                        O1_DOG_L2L3_done
);

    localparam int KP_ROW_LSB = KP_COL_LSB + CW;

    fk_state_e state_r, state_s;

    logic [CW-1:0]    row_r, col_r, w_max_s, pr_s, pc_s;
    logic [3:0]       tap_r;
    logic             drain_r, issuing_s, last_issue_s, start_accept_s, pipe_empty_s;
    logic [OCT_W-1:0] oct_s;
    logic [A1W-1:0]   o1_addr_r;
    logic [A2W-1:0]   o2_addr_r;
    logic [A3W-1:0]   o3_addr_r;

    logic             tag_a_vld_r, tag_b_vld_r, tag_c_vld_r;
    logic [3:0]       tag_a_tap_r, tag_b_tap_r, tag_c_tap_r;
    logic [CW-1:0]    tag_a_row_r, tag_b_row_r, tag_c_row_r;
    logic [CW-1:0]    tag_a_col_r, tag_b_col_r, tag_c_col_r;
    logic [OCT_W-1:0] tag_a_oct_r, tag_b_oct_r, tag_c_oct_r;

    logic signed [BIT_DEPTH-1:0] l1_s, l2_s, l3_s;
    logic             is_max_s, is_min_s;
    logic             eval_r;
    logic [CW-1:0]    eval_row_r, eval_col_r;

    logic [A1W-1:0]   count_r, key_addr_r;
    logic             full_r, key_wea_r;
    logic [2*CW:0]    keypoint_r;
    logic             done_r, oct3_r, o1_done_r;

    // Per-octave scan geometry derived from the current state.
    always_comb begin
        w_max_s = CW'(DIMENSION - 2);
        oct_s   = OCT_W'(0);
        case (state_r)
            SCAN_O1: begin w_max_s = CW'(DIMENSION - 2);     oct_s = OCT_W'(0); end
            SCAN_O2: begin w_max_s = CW'(DIMENSION / 2 - 2); oct_s = OCT_W'(1); end
            SCAN_O3: begin w_max_s = CW'(DIMENSION / 4 - 2); oct_s = OCT_W'(2); end
            default: begin w_max_s = CW'(DIMENSION - 2);     oct_s = OCT_W'(0); end
        endcase
    end

    assign issuing_s      = (state_r == SCAN_O1) || (state_r == SCAN_O2) ||
                            ((state_r == SCAN_O3) && !drain_r);
    assign last_issue_s   = issuing_s && (row_r == w_max_s) && (col_r == w_max_s) &&
                            (tap_r == LAST_TAP);
    assign start_accept_s = start && ((state_r == IDLE) || (state_r == DONE));
    assign pipe_empty_s   = !tag_a_vld_r && !tag_b_vld_r && !tag_c_vld_r && !eval_r;
    assign pr_s           = row_r + CW'(tap_row(tap_r)) - CW'(1);
    assign pc_s           = col_r + CW'(tap_col(tap_r)) - CW'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) state_r <= IDLE;
        else         state_r <= state_s;
    end

    // Next-state logic; octave 3 waits for in-flight windows before DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE: if (start)                     state_s = SCAN_O1; else state_s = state_r;
            SCAN_O1:    if (last_issue_s)              state_s = SCAN_O2; else state_s = state_r;
            SCAN_O2:    if (last_issue_s)              state_s = SCAN_O3; else state_s = state_r;
            SCAN_O3:    if (drain_r && pipe_empty_s)   state_s = DONE;    else state_s = state_r;
            default:                                   state_s = IDLE;
        endcase
    end

    // Candidate/tap counters walking interior pixels row-major.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            row_r <= CW'(1); col_r <= CW'(1); tap_r <= 4'd0; drain_r <= 1'b0;
        end else if ((state_r == IDLE) || (state_r == DONE)) begin
            row_r <= CW'(1); col_r <= CW'(1); tap_r <= 4'd0; drain_r <= 1'b0;
        end else if (issuing_s) begin
            if (tap_r == LAST_TAP) begin
                tap_r <= 4'd0;
                if (col_r == w_max_s) begin
                    col_r <= CW'(1);
                    if (row_r == w_max_s) begin
                        row_r   <= CW'(1);
                        drain_r <= (state_r == SCAN_O3);
                    end else begin
                        row_r <= row_r + CW'(1);
                    end
                end else begin
                    col_r <= col_r + CW'(1);
                end
            end else begin
                tap_r <= tap_r + 4'd1;
            end
        end
    end

    // Registered BRAM addresses plus the tag pipeline aligned to read latency.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            o1_addr_r <= '0; o2_addr_r <= '0; o3_addr_r <= '0;
            tag_a_vld_r <= 1'b0; tag_a_tap_r <= 4'd0; tag_a_row_r <= '0; tag_a_col_r <= '0; tag_a_oct_r <= '0;
            tag_b_vld_r <= 1'b0; tag_b_tap_r <= 4'd0; tag_b_row_r <= '0; tag_b_col_r <= '0; tag_b_oct_r <= '0;
            tag_c_vld_r <= 1'b0; tag_c_tap_r <= 4'd0; tag_c_row_r <= '0; tag_c_col_r <= '0; tag_c_oct_r <= '0;
        end else begin
            o1_addr_r <= (issuing_s && (state_r == SCAN_O1)) ? {pr_s, pc_s} : '0;
            o2_addr_r <= (issuing_s && (state_r == SCAN_O2)) ? {pr_s[CW-2:0], pc_s[CW-2:0]} : '0;
            o3_addr_r <= (issuing_s && (state_r == SCAN_O3)) ? {pr_s[CW-3:0], pc_s[CW-3:0]} : '0;
            tag_a_vld_r <= issuing_s;   tag_a_tap_r <= tap_r;
            tag_a_row_r <= row_r;       tag_a_col_r <= col_r;       tag_a_oct_r <= oct_s;
            tag_b_vld_r <= tag_a_vld_r; tag_b_tap_r <= tag_a_tap_r;
            tag_b_row_r <= tag_a_row_r; tag_b_col_r <= tag_a_col_r; tag_b_oct_r <= tag_a_oct_r;
            tag_c_vld_r <= tag_b_vld_r; tag_c_tap_r <= tag_b_tap_r;
            tag_c_row_r <= tag_b_row_r; tag_c_col_r <= tag_b_col_r; tag_c_oct_r <= tag_b_oct_r;
        end
    end

    // Pick the octave whose data is arriving this cycle.
    always_comb begin
        l1_s = O1L1_data; l2_s = O1L2_data; l3_s = O1L3_data;
        case (tag_c_oct_r)
            OCT_W'(0): begin l1_s = O1L1_data; l2_s = O1L2_data; l3_s = O1L3_data; end
            OCT_W'(1): begin l1_s = O2L1_data; l2_s = O2L2_data; l3_s = O2L3_data; end
            OCT_W'(2): begin l1_s = O3L1_data; l2_s = O3L2_data; l3_s = O3L3_data; end
            default:   begin l1_s = O1L1_data; l2_s = O1L2_data; l3_s = O1L3_data; end
        endcase
    end

    extremum_window_27 #(.BIT_DEPTH(BIT_DEPTH)) u_window (
        .clk     (clk),
        .rst_n   (rst_in),
        .cap_en  (tag_c_vld_r),
        .cap_tap (tag_c_tap_r),
        .l1      (l1_s),
        .l2      (l2_s),
        .l3      (l3_s),
        .is_max  (is_max_s),
        .is_min  (is_min_s)
    );

    // Flag the cycle after a window's final capture for evaluation.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            eval_r <= 1'b0; eval_row_r <= '0; eval_col_r <= '0;
        end else begin
            eval_r     <= tag_c_vld_r && (tag_c_tap_r == LAST_TAP);
            eval_row_r <= tag_c_row_r;
            eval_col_r <= tag_c_col_r;
        end
    end

    // Keypoint write port; the counter saturates after filling the last slot.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            count_r <= '0; full_r <= 1'b0; key_wea_r <= 1'b0; key_addr_r <= '0; keypoint_r <= '0;
        end else if (start_accept_s) begin
            count_r <= '0; full_r <= 1'b0; key_wea_r <= 1'b0; key_addr_r <= '0; keypoint_r <= '0;
        end else if (eval_r && (is_max_s || is_min_s) && !full_r) begin
            key_wea_r                           <= 1'b1;
            key_addr_r                          <= count_r;
            keypoint_r[KP_ROW_LSB +: CW]        <= eval_row_r;
            keypoint_r[KP_COL_LSB +: CW]        <= eval_col_r;
            keypoint_r[KP_IS_MAX_LSB]           <= is_max_s;
            if (count_r == '1) full_r  <= 1'b1;
            else               count_r <= count_r + A1W'(1);
        end else begin
            key_wea_r <= 1'b0;
        end
    end

    // Scan status flags.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            done_r <= 1'b0; oct3_r <= 1'b0; o1_done_r <= 1'b0;
        end else begin
            done_r    <= (state_s == DONE);
            oct3_r    <= (state_s == SCAN_O3) ? 1'b1 : (start_accept_s ? 1'b0 : oct3_r);
            o1_done_r <= (state_r == SCAN_O1) && (state_s == SCAN_O2);
        end
    end

    assign O1L1_read_addr      = o1_addr_r;
    assign O1L2_read_addr      = o1_addr_r;
    assign O1L3_read_addr      = o1_addr_r;
    assign O2L1_read_addr      = o2_addr_r;
    assign O2L2_read_addr      = o2_addr_r;
    assign O2L3_read_addr      = o2_addr_r;
    assign O3L1_read_addr      = o3_addr_r;
    assign O3L2_read_addr      = o3_addr_r;
    assign O3L3_read_addr      = o3_addr_r;
    assign kp.key_write_addr   = key_addr_r;
    assign kp.key_wea          = key_wea_r;
    assign kp.keypoint_out     = keypoint_r;
    assign keypoints_done      = done_r;
    assign in_ocatve_3_latched = oct3_r;
    assign O1_DOG_L2L3_done    = o1_done_r;

endmodule

// File: tb/tb_find_keypoints_unit.sv
// Directed bench for find_keypoints_unit at DIMENSION=16 (octaves 16/8/4).
module tb_find_keypoints_unit;

    localparam int BD  = 8;
    localparam int DIM = 16;

    logic clk = 1'b0;
    logic rst_in, start;
    logic [7:0] O1L1_read_addr, O1L2_read_addr, O1L3_read_addr;
    logic [5:0] O2L1_read_addr, O2L2_read_addr, O2L3_read_addr;
    logic [3:0] O3L1_read_addr, O3L2_read_addr, O3L3_read_addr;
    logic signed [BD-1:0] O1L1_data, O1L2_data, O1L3_data;
    logic signed [BD-1:0] O2L1_data, O2L2_data, O2L3_data;
    logic signed [BD-1:0] O3L1_data, O3L2_data, O3L3_data;
    logic keypoints_done, in_ocatve_3_latched, O1_DOG_L2L3_done;

    logic signed [BD-1:0] m1l1 [256], m1l2 [256], m1l3 [256];
    logic signed [BD-1:0] m2l1 [64],  m2l2 [64],  m2l3 [64];
    logic signed [BD-1:0] m3l1 [16],  m3l2 [16],  m3l3 [16];
    logic signed [BD-1:0] p1l1, p1l2, p1l3, p2l1, p2l2, p2l3, p3l1, p3l2, p3l3;

    find_keypoints_unit_if #(.DIMENSION(DIM)) kp_bus ();

    find_keypoints_unit #(.BIT_DEPTH(BD), .DIMENSION(DIM)) dut (
        .clk(clk), .rst_in(rst_in), .start(start),
        .O1L1_read_addr(O1L1_read_addr), .O1L2_read_addr(O1L2_read_addr), .O1L3_read_addr(O1L3_read_addr),
        .O1L1_data(O1L1_data), .O1L2_data(O1L2_data), .O1L3_data(O1L3_data),
        .O2L1_read_addr(O2L1_read_addr), .O2L2_read_addr(O2L2_read_addr), .O2L3_read_addr(O2L3_read_addr),
        .O2L1_data(O2L1_data), .O2L2_data(O2L2_data), .O2L3_data(O2L3_data),
        .O3L1_read_addr(O3L1_read_addr), .O3L2_read_addr(O3L2_read_addr), .O3L3_read_addr(O3L3_read_addr),
        .O3L1_data(O3L1_data), .O3L2_data(O3L2_data), .O3L3_data(O3L3_data),
        .kp(kp_bus),
        .keypoints_done(keypoints_done), .in_ocatve_3_latched(in_ocatve_3_latched),
        .O1_DOG_L2L3_done(O1_DOG_L2L3_done)
    );

    always #5 clk = ~clk;

    // Two-cycle read latency BRAM models.
    always @(posedge clk) begin
        p1l1 <= m1l1[O1L1_read_addr]; O1L1_data <= p1l1;
        p1l2 <= m1l2[O1L2_read_addr]; O1L2_data <= p1l2;
        p1l3 <= m1l3[O1L3_read_addr]; O1L3_data <= p1l3;
        p2l1 <= m2l1[O2L1_read_addr]; O2L1_data <= p2l1;
        p2l2 <= m2l2[O2L2_read_addr]; O2L2_data <= p2l2;
        p2l3 <= m2l3[O2L3_read_addr]; O2L3_data <= p2l3;
        p3l1 <= m3l1[O3L1_read_addr]; O3L1_data <= p3l1;
        p3l2 <= m3l2[O3L2_read_addr]; O3L2_data <= p3l2;
        p3l3 <= m3l3[O3L3_read_addr]; O3L3_data <= p3l3;
    end

    // Keypoint write and octave-1 pulse recorder.
    int         n_wr = 0;
    int         n_pulse = 0;
    logic [7:0] wr_addr [64];
    logic [8:0] wr_word [64];
    logic       wr_lat  [64];
    int         wr_pulse[64];
    always @(negedge clk) begin
        if (rst_in && O1_DOG_L2L3_done) n_pulse <= n_pulse + 1;
        if (rst_in && kp_bus.key_wea && (n_wr < 64)) begin
            wr_addr[n_wr]  <= kp_bus.key_write_addr;
            wr_word[n_wr]  <= kp_bus.keypoint_out;
            wr_lat[n_wr]   <= in_ocatve_3_latched;
            wr_pulse[n_wr] <= n_pulse;
            n_wr           <= n_wr + 1;
        end
    end

    int checks = 0;
    int failures = 0;
    int wbase, pbase, cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin m1l1[i] = '0; m1l2[i] = '0; m1l3[i] = '0; end
        for (int i = 0; i < 64; i++)  begin m2l1[i] = '0; m2l2[i] = '0; m2l3[i] = '0; end
        for (int i = 0; i < 16; i++)  begin m3l1[i] = '0; m3l2[i] = '0; m3l3[i] = '0; end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!keypoints_done && (c < 6000)) begin @(negedge clk); c++; end
        check(tag, keypoints_done, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_scan(input string tag);
        wbase = n_wr; pbase = n_pulse;
        pulse_start();
        wait_done(tag);
    endtask

    initial begin
        rst_in = 1'b0; start = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_wea",   kp_bus.key_wea, 32'd0);
        check("rst_waddr", kp_bus.key_write_addr, 32'd0);
        check("rst_word",  kp_bus.keypoint_out, 32'd0);
        check("rst_done",  keypoints_done, 32'd0);
        check("rst_o3",    in_ocatve_3_latched, 32'd0);
        check("rst_o1p",   O1_DOG_L2L3_done, 32'd0);
        check("rst_a1",    O1L1_read_addr, 32'd0);
        rst_in = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero layers: nothing written, flags raised, one octave-1 pulse.
        run_scan("zero_done");
        check("zero_writes", n_wr - wbase, 32'd0);
        check("zero_o3",     in_ocatve_3_latched, 32'd1);
        check("zero_pulses", n_pulse - pbase, 32'd1);
        check("zero_a2_idle", O2L1_read_addr, 32'd0);

        // Single octave-1 maximum at (10,12).
        m1l2[10*16+12] = 8'sd100;
        run_scan("o1max_done");
        check("o1max_writes", n_wr - wbase, 32'd1);
        check("o1max_word",   wr_word[wbase], 32'd345);
        check("o1max_addr",   wr_addr[wbase], 32'd0);

        // Single octave-2 minimum at (5,6).
        clear_mem();
        m2l2[5*8+6] = -8'sd127;
        run_scan("o2min_done");
        check("o2min_writes", n_wr - wbase, 32'd1);
        check("o2min_word",   wr_word[wbase], 32'd172);
        check("o2min_addr",   wr_addr[wbase], 32'd0);
        check("o2min_after_o1", wr_pulse[wbase] - pbase, 32'd1);
        check("o2min_o3lat",  wr_lat[wbase], 32'd0);

        // Tie across layers suppresses the keypoint.
        clear_mem();
        m1l2[10*16+12] = 8'sd100;
        m1l3[11*16+13] = 8'sd100;
        run_scan("tie_done");
        check("tie_writes", n_wr - wbase, 32'd0);

        // Border peak is never a keypoint.
        clear_mem();
        m1l2[0*16+5] = 8'sd100;
        run_scan("border_done");
        check("border_writes", n_wr - wbase, 32'd0);

        // One peak per octave: addresses 0,1,2 in octave order.
        clear_mem();
        m1l2[3*16+3] = 8'sd50;
        m2l2[2*8+2]  = -8'sd10;
        m3l2[1*4+2]  = 8'sd77;
        run_scan("three_done");
        check("three_writes", n_wr - wbase, 32'd3);
        check("three_w0", wr_word[wbase],   32'd103);
        check("three_a0", wr_addr[wbase],   32'd0);
        check("three_w1", wr_word[wbase+1], 32'd68);
        check("three_a1", wr_addr[wbase+1], 32'd1);
        check("three_w2", wr_word[wbase+2], 32'd37);
        check("three_a2", wr_addr[wbase+2], 32'd2);
        check("three_lat2", wr_lat[wbase+2], 32'd1);

        // Reset in the middle of octave 2.
        clear_mem();
        m1l2[10*16+12] = 8'sd100;
        wbase = n_wr; pbase = n_pulse;
        pulse_start();
        cyc = 0;
        while ((n_pulse == pbase) && (cyc < 4000)) begin @(negedge clk); cyc++; end
        check("mid_pulse_seen", 32'(n_pulse != pbase), 32'd1);
        repeat (20) @(negedge clk);
        check("mid_pre_waddr", kp_bus.key_write_addr, 32'd0);
        check("mid_pre_writes", n_wr - wbase, 32'd1);
        #2 rst_in = 1'b0;
        #1;
        check("mid_rst_wea",   kp_bus.key_wea, 32'd0);
        check("mid_rst_word",  kp_bus.keypoint_out, 32'd0);
        check("mid_rst_a2",    O2L1_read_addr, 32'd0);
        check("mid_rst_done",  keypoints_done, 32'd0);
        check("mid_rst_o3",    in_ocatve_3_latched, 32'd0);
        repeat (2) @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);

        // Fresh scan restarts from O1 at address 0; a mid-scan start is ignored.
        wbase = n_wr; pbase = n_pulse;
        pulse_start();
        cyc = 0;
        while ((n_pulse == pbase) && (cyc < 4000)) begin @(negedge clk); cyc++; end
        pulse_start();
        wait_done("restart_done");
        check("restart_writes", n_wr - wbase, 32'd1);
        check("restart_word",   wr_word[wbase], 32'd345);
        check("restart_addr",   wr_addr[wbase], 32'd0);
        check("restart_pulses", n_pulse - pbase, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
